// File: rtl/f2_inst_queue.sv
// Instruction queue between F2 fetch and D1 decode: expands fetch packets into
// per-instruction entries in a circular FIFO and presents the head to decode.
module f2_inst_queue #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned CL_SIZE = 128,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       pkt_valid,
  input  logic [CL_SIZE-1:0]         pkt_line,
  input  logic [XLEN-1:0]            pkt_pc,
  input  logic                       pkt_exc,
  output logic                       stall_out,
  input  logic                       deq_ready,
  output logic                       inst_valid,
  output logic [XLEN-1:0]            inst_out,
  output logic [XLEN-1:0]            inst_pc,
  output logic                       inst_exc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] StallThr = CW'(DEPTH - 4);

  logic [XLEN-1:0] inst_q [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic            exc_q  [DEPTH];

  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          exc_pkt;
  logic [1:0]    start;
  logic [2:0]    n_wr;
  logic          accept;
  logic          deq;

  logic            wr_en   [4];
  logic [PW-1:0]   wr_idx  [4];
  logic [XLEN-1:0] wr_inst [4];
  logic [XLEN-1:0] wr_pc   [4];

  always_comb begin
    exc_pkt   = pkt_exc | (pkt_pc[1:0] != 2'b00);
    start     = pkt_pc[3:2];
    n_wr      = exc_pkt ? 3'd1 : (3'd4 - {1'b0, start});
    stall_out = count_q > StallThr;
    accept    = pkt_valid & ~stall_out & ~flush;
    deq       = (count_q != '0) & deq_ready & ~flush;
  end

  // Lane i carries packet word (start + i); lanes beyond n_wr are inert.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      logic [1:0] w;
      w          = start + 2'(i);
      wr_en[i]   = accept && (3'(i) < n_wr);
      wr_idx[i]  = wptr_q + PW'(i);
      wr_inst[i] = exc_pkt ? '0 : pkt_line[32*int'(w) +: XLEN];
      wr_pc[i]   = exc_pkt ? pkt_pc : {pkt_pc[XLEN-1:4], w, 2'b00};
    end
  end

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (accept) wptr_d = wptr_q + PW'(n_wr);
      if (deq)    rptr_d = rptr_q + PW'(1);
      count_d = count_q + (accept ? CW'(n_wr) : CW'(0)) - (deq ? CW'(1) : CW'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count marks them valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en[i]) begin
        inst_q[wr_idx[i]] <= wr_inst[i];
        pc_q[wr_idx[i]]   <= wr_pc[i];
        exc_q[wr_idx[i]]  <= exc_pkt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_d <= CW'(DEPTH));
    end
  end

  always_comb begin
    inst_valid = count_q != '0;
    count      = count_q;
    inst_out   = inst_valid ? inst_q[rptr_q] : '0;
    inst_pc    = inst_valid ? pc_q[rptr_q]   : '0;
    inst_exc   = inst_valid ? exc_q[rptr_q]  : 1'b0;
  end

endmodule

// File: tb/tb_f2_inst_queue.sv
// Directed bench for f2_inst_queue: vector table for fill/offset/backpressure/
// exception/flush, plus hand sequences for reset and sustained wrap traffic.
module tb_f2_inst_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         pkt_valid;
  logic [127:0] pkt_line;
  logic [31:0]  pkt_pc;
  logic         pkt_exc;
  logic         stall_out;
  logic         deq_ready;
  logic         inst_valid;
  logic [31:0]  inst_out;
  logic [31:0]  inst_pc;
  logic         inst_exc;
  logic [3:0]   count;

  f2_inst_queue #(.XLEN(32), .CL_SIZE(128), .DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .pkt_valid  (pkt_valid),
    .pkt_line   (pkt_line),
    .pkt_pc     (pkt_pc),
    .pkt_exc    (pkt_exc),
    .stall_out  (stall_out),
    .deq_ready  (deq_ready),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .inst_exc   (inst_exc),
    .count      (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         pv;
    logic [31:0]  pc;
    logic [127:0] line;
    logic         exc;
    logic         fl;
    logic         dq;
    logic         ev;
    logic [31:0]  ei;
    logic [31:0]  ep;
    logic         ee;
    logic [3:0]   ec;
    logic         es;
  } vec_t;

  localparam logic [127:0] L1 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [127:0] L2 = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
  localparam logic [127:0] Z  = '0;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t tbl[$];

  function automatic vec_t v(logic pv, logic [31:0] pc, logic [127:0] line, logic exc,
                             logic fl, logic dq, logic ev, logic [31:0] ei,
                             logic [31:0] ep, logic ee, logic [3:0] ec, logic es);
    vec_t r;
    r.pv = pv; r.pc = pc; r.line = line; r.exc = exc; r.fl = fl; r.dq = dq;
    r.ev = ev; r.ei = ei; r.ep = ep; r.ee = ee; r.ec = ec; r.es = es;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [31:0] pc, input logic [127:0] line,
                       input logic exc, input logic fl, input logic dq);
    pkt_valid = pv; pkt_pc = pc; pkt_line = line; pkt_exc = exc;
    flush = fl; deq_ready = dq;
  endtask

  task automatic check_head(input string tag, input logic ev, input logic [31:0] ei,
                            input logic [31:0] ep, input logic ee, input logic [3:0] ec,
                            input logic es);
    chk({tag, " inst_valid"}, 32'(inst_valid), 32'(ev));
    chk({tag, " inst_out"},   inst_out,        ei);
    chk({tag, " inst_pc"},    inst_pc,         ep);
    chk({tag, " inst_exc"},   32'(inst_exc),   32'(ee));
    chk({tag, " count"},      32'(count),      32'(ec));
    chk({tag, " stall_out"},  32'(stall_out),  32'(es));
  endtask

  initial begin
    // Aligned fill, drained one per cycle.
    tbl.push_back(v(1, 'h100, L1, 0, 0, 1, 0, 0,     0,     0, 0, 0));
    tbl.push_back(v(0, 0,     Z,  0, 0, 1, 1, 'hA0, 'h100, 0, 4, 0));
    tbl.push_back(v(0, 0,     Z,  0, 0, 1, 1, 'hA1, 'h104, 0, 3, 0));
    tbl.push_back(v(0, 0,     Z,  0, 0, 1, 1, 'hA2, 'h108, 0, 2, 0));
    tbl.push_back(v(0, 0,     Z,  0, 0, 1, 1, 'hA3, 'h10C, 0, 1, 0));
    tbl.push_back(v(0, 0,     Z,  0, 0, 1, 0, 0,     0,     0, 0, 0));
    // Offset start: only words 2 and 3.
    tbl.push_back(v(1, 'h208, L2, 0, 0, 0, 0, 0,     0,     0, 0, 0));
    tbl.push_back(v(0, 0,     Z,  0, 0, 0, 1, 'hB2, 'h208, 0, 2, 0));
    tbl.push_back(v(0, 0,     Z,  0, 0, 1, 1, 'hB2, 'h208, 0, 2, 0));
    tbl.push_back(v(0, 0,     Z,  0, 0, 1, 1, 'hB3, 'h20C, 0, 1, 0));
    tbl.push_back(v(0, 0,     Z,  0, 0, 0, 0, 0,     0,     0, 0, 0));
    // Backpressure: third packet held while stalled, accepted once room exists.
    tbl.push_back(v(1, 'h600, L1, 0, 0, 0, 0, 0,     0,     0, 0, 0));
    tbl.push_back(v(1, 'h610, L2, 0, 0, 0, 1, 'hA0, 'h600, 0, 4, 0));
    tbl.push_back(v(1, 'h620, L1, 0, 0, 0, 1, 'hA0, 'h600, 0, 8, 1));
    tbl.push_back(v(1, 'h620, L1, 0, 0, 1, 1, 'hA0, 'h600, 0, 8, 1));
    tbl.push_back(v(1, 'h620, L1, 0, 0, 1, 1, 'hA1, 'h604, 0, 7, 1));
    tbl.push_back(v(1, 'h620, L1, 0, 0, 1, 1, 'hA2, 'h608, 0, 6, 1));
    tbl.push_back(v(1, 'h620, L1, 0, 0, 1, 1, 'hA3, 'h60C, 0, 5, 1));
    tbl.push_back(v(1, 'h620, L1, 0, 0, 0, 1, 'hB0, 'h610, 0, 4, 0));
    tbl.push_back(v(0, 0,     Z,  0, 0, 1, 1, 'hB0, 'h610, 0, 8, 1));
    tbl.push_back(v(0, 0,     Z,  0, 0, 1, 1, 'hB1, 'h614, 0, 7, 1));
    tbl.push_back(v(0, 0,     Z,  0, 0, 1, 1, 'hB2, 'h618, 0, 6, 1));
    tbl.push_back(v(0, 0,     Z,  0, 0, 1, 1, 'hB3, 'h61C, 0, 5, 1));
    tbl.push_back(v(0, 0,     Z,  0, 0, 1, 1, 'hA0, 'h620, 0, 4, 0));
    tbl.push_back(v(0, 0,     Z,  0, 0, 1, 1, 'hA1, 'h624, 0, 3, 0));
    tbl.push_back(v(0, 0,     Z,  0, 0, 1, 1, 'hA2, 'h628, 0, 2, 0));
    tbl.push_back(v(0, 0,     Z,  0, 0, 1, 1, 'hA3, 'h62C, 0, 1, 0));
    tbl.push_back(v(0, 0,     Z,  0, 0, 0, 0, 0,     0,     0, 0, 0));
    // Exceptions: misaligned PC and flagged packet, one entry each.
    tbl.push_back(v(1, 'h302, L1, 0, 0, 0, 0, 0,     0,     0, 0, 0));
    tbl.push_back(v(1, 'h400, L1, 1, 0, 0, 1, 0,     'h302, 1, 1, 0));
    tbl.push_back(v(0, 0,     Z,  0, 0, 1, 1, 0,     'h302, 1, 2, 0));
    tbl.push_back(v(0, 0,     Z,  0, 0, 1, 1, 0,     'h400, 1, 1, 0));
    tbl.push_back(v(0, 0,     Z,  0, 0, 0, 0, 0,     0,     0, 0, 0));
    // Flush at count 6 with a packet and dequeue in the same cycle.
    tbl.push_back(v(1, 'h708, L1, 0, 0, 0, 0, 0,     0,     0, 0, 0));
    tbl.push_back(v(1, 'h700, L1, 0, 0, 0, 1, 'hA2, 'h708, 0, 2, 0));
    tbl.push_back(v(0, 0,     Z,  0, 0, 0, 1, 'hA2, 'h708, 0, 6, 1));
    tbl.push_back(v(1, 'h800, L1, 0, 1, 1, 1, 'hA2, 'h708, 0, 6, 1));
    tbl.push_back(v(1, 'h500, L2, 0, 0, 0, 0, 0,     0,     0, 0, 0));
    tbl.push_back(v(0, 0,     Z,  0, 0, 0, 1, 'hB0, 'h500, 0, 4, 0));

    rst = 1'b1;
    drive(1, 'h900, L1, 0, 1, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].pv, tbl[r].pc, tbl[r].line, tbl[r].exc, tbl[r].fl, tbl[r].dq);
      #1;
      check_head($sformatf("row%0d", r), tbl[r].ev, tbl[r].ei, tbl[r].ep, tbl[r].ee,
                 tbl[r].ec, tbl[r].es);
      @(negedge clk);
    end

    // Reset mid-operation (count 4) overrides packet and dequeue.
    rst = 1'b1;
    drive(1, 'hA00, L1, 0, 0, 1);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, Z, 0, 0, 0);
    #1;
    check_head("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Sustained traffic across pointer wrap against a FIFO model.
    begin
      logic [63:0]  mq[$];
      logic [127:0] line;
      logic         exp_stall;
      int k = 0, deqd = 0, cyc = 0;
      while (deqd < 80 && cyc < 300) begin
        for (int j = 0; j < 4; j++) line[32*j +: 32] = 32'hC000_0000 | (k << 4) | j;
        drive(k < 20, 32'h1000 + 32'(k) * 16, line, 0, 0, 1);
        #1;
        exp_stall = mq.size() > 4;
        chk("wrap stall_out", 32'(stall_out), 32'(exp_stall));
        chk("wrap count", 32'(count), 32'(mq.size()));
        chk("wrap count<=8", 32'(count <= 4'd8), 32'd1);
        chk("wrap inst_valid", 32'(inst_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
          chk("wrap inst_out", inst_out, mq[0][63:32]);
          chk("wrap inst_pc", inst_pc, mq[0][31:0]);
          void'(mq.pop_front());
          deqd++;
        end
        if (k < 20 && !exp_stall) begin
          for (int j = 0; j < 4; j++) mq.push_back({line[32*j +: 32], 32'h1000 + 32'(k) * 16 + 32'(j) * 4});
          k++;
        end
        cyc++;
        @(negedge clk);
      end
      chk("wrap dequeued total", 32'(deqd), 32'd80);
      drive(0, 0, Z, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/f2_inst_queue.md
Name: f2_inst_queue

Overview:
- Sits between the F2 fetch stage and the D1 decoder.
- Accepts one fetch packet per cycle from F2: a 128-bit cache line, the fetch PC and an exception flag.
- Extracts the 32-bit instructions from the fetch PC's word offset to the end of the line, and queues them in a circular FIFO.
- Hands instructions to decode one per cycle under a valid/ready handshake.
- Backpressures F2 through stall_out and discards all contents on a resteer flush.

Parameters:
- XLEN, 32, PC and instruction width.
- CL_SIZE, 128, cache line width in bits; 4 instructions per line.
- DEPTH, 8, queue capacity in instructions; power of 2, minimum 4.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- flush  input  1  resteer; discard all queued entries and any same-cycle packet
- pkt_valid  input  1  F2 presents a fetch packet this cycle
- pkt_line  input  CL_SIZE  fetched cache line; word k at bits [32k+31:32k]
- pkt_pc  input  XLEN  fetch PC of the packet
- pkt_exc  input  1  fetch exception for this packet
- stall_out  output  1  queue cannot guarantee room for a full packet; F2 must hold
- deq_ready  input  1  decode consumes the head entry this cycle
- inst_valid  output  1  head entry valid
- inst_out  output  XLEN  head instruction
- inst_pc  output  XLEN  PC of the head instruction
- inst_exc  output  1  head entry carries an exception
- count  output  $clog2(DEPTH)+1  number of occupied entries

Behaviour:
- Reset: rst=1 sets read pointer, write pointer and count to 0.
  - Next cycle: inst_valid=0, inst_out=0, inst_pc=0, inst_exc=0, stall_out=0.
  - Reset overrides flush and all handshakes.
- Storage: DEPTH entries of {inst, pc, exc}, circular.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is tracked separately, so full (count==DEPTH) and empty (count==0) are unambiguous.
- stall_out: combinational, equal to (DEPTH - count) < 4.
  - Computed from the current count only; a same-cycle dequeue is not credited.
- Accept condition: pkt_valid & ~stall_out & ~flush.
  - If pkt_valid=1 while stall_out=1, the packet is ignored and nothing is written. F2 is required to hold it.
- Packet expansion for a normal packet (pkt_exc=0 and pkt_pc[1:0]==0):
  - Start word s = pkt_pc[3:2]; entries written N = 4 - s (1..4).
  - Entry i (0..N-1) takes inst = pkt_line word (s+i) and pc = {pkt_pc[XLEN-1:4], (s+i), 2'b00}, with exc=0.
  - Entries are written to wptr, wptr+1, ... with wrap-around, all in the same cycle.
- Exception packet (pkt_exc=1, or pkt_pc[1:0]!=0):
  - Exactly one entry is written: inst=0, pc=pkt_pc, exc=1. N=1.
- Dequeue: fires when inst_valid & deq_ready.
  - rptr advances by 1 and count decrements by 1.
  - deq_ready while empty has no effect.
- Simultaneous enqueue and dequeue: count_next = count + N - 1. Both pointers update in the same cycle.
- Head outputs:
  - inst_valid = (count != 0).
  - inst_out, inst_pc and inst_exc are read combinationally from entry rptr.
  - When empty, these three outputs are forced to 0.
- Latency: a packet accepted in cycle t is visible at the head in cycle t+1 when the queue was empty. There is no bypass.
- Flush: in the next cycle rptr=wptr=0 and count=0.
  - Any same-cycle packet or dequeue is discarded.
  - inst_valid=0 in the cycle after flush.
  - The stale storage contents are unobservable.
- Order: strict FIFO by program order within a packet (ascending word index) and across packets.
- Invariant: count never exceeds DEPTH. An overflow is impossible by construction and is asserted in simulation.

Test Plan:
1. Aligned fill:
   - Stimulus: reset; packet pc=0x100, line words {W0,W1,W2,W3}=0xA0,0xA1,0xA2,0xA3; deq_ready=1.
   - Required: from the next cycle, dequeues give 0xA0@0x100, 0xA1@0x104, 0xA2@0x108, 0xA3@0x10C; count goes 4→3→2→1→0.
2. Offset start:
   - Stimulus: packet pc=0x208.
   - Required: only 2 entries, word2@0x208 and word3@0x20C; count=2.
3. Backpressure:
   - Stimulus: deq_ready=0; two aligned packets.
   - Required: count=8, stall_out=1. A third packet held with pkt_valid=1 is not written.
   - Then one dequeue: count=7, stall_out still 1. After 4 dequeues: stall_out=0.
4. Wrap and concurrent traffic:
   - Stimulus: 20 consecutive aligned packets with deq_ready=1 throughout.
   - Required: 80 instructions dequeued in order with correct PCs; count never exceeds 8.
5. Exception:
   - Stimulus: packet pc=0x302 (misaligned), and separately pc=0x400 with pkt_exc=1.
   - Required: one entry each, with inst_exc=1, inst_out=0, inst_pc equal to the packet PC.
6. Flush mid-operation:
   - Stimulus: count=6; flush asserted together with pkt_valid and deq_ready.
   - Required: next cycle count=0, inst_valid=0, stall_out=0. A following packet at pc=0x500 appears at the head one cycle after it is accepted.
